l2_way_select: RTL and testbench
================================

// Module: l2_way_select
// PURPOSE
//  Resolves the target way for each L2 request from the registered tag-lookup result.
//  Sits directly downstream of the L2 tag/state lookup stage.
//  Owns the per-set round-robin eviction pointer; evict_way_buf is fed back to the lookup stage.
//  Priority is hit, then empty way, then victim. The victim search skips ways whose lines are busy (transient).
// PARAMETERS
//  L2_SETS   256  number of sets; SET_BITS = $clog2(L2_SETS)
//  L2_WAYS   8    associativity, power of two; WAY_BITS = $clog2(L2_WAYS)
// PORTS
//  clk              in   1         clock
//  rst              in   1         reset, asynchronous, active-low
//  sel_req_valid    in   1         lookup result valid this cycle
//  sel_req_ready    out  1         block can accept a request
//  set_in           in   SET_BITS  set index of the request
//  tag_hit          in   1         lookup hit
//  way_hit          in   WAY_BITS  hit way
//  empty_way_found  in   1         an INVALID way exists
//  empty_way        in   WAY_BITS  lowest INVALID way
//  way_busy         in   L2_WAYS   per-way transient/pending flag for set_in
//  evict_way_buf    out  WAY_BITS  eviction pointer of set_in (combinational read)
//  sel_valid        out  1         result valid
//  sel_ready        in   1         consumer accepts result
//  sel_way          out  WAY_BITS  chosen way
//  sel_kind         out  2         00 HIT, 01 FILL, 10 EVICT, 11 STALL (no victim available)
//  stat_hits, stat_fills, stat_evicts, stat_stalls  out  32 each  see CONFIGURATION
// BEHAVIOUR
//  Reset (async, rst=0):
//   - all eviction pointers = 0; FSM = IDLE
//   - sel_valid = 0, sel_way = 0, sel_kind = 00, all stat_* = 0
//   - a reset mid-scan or mid-output drops the request with no pointer update
//  FSM states: IDLE, SCAN, OUT.
//  sel_req_ready = (state == IDLE).
//  Accept = sel_req_valid && sel_req_ready. On accept, latch set_in, way_busy, and ptr = evict_ptr[set_in].
//  IDLE, on accept (first matching rule wins):
//   - tag_hit: sel_way = way_hit, kind HIT, go to OUT.
//   - else empty_way_found: sel_way = empty_way, kind FILL, go to OUT.
//   - else !busy[ptr]: sel_way = ptr, kind EVICT, go to OUT.
//   - else: cnt = 1, go to SCAN.
//  SCAN, one way examined per cycle, w = (ptr + cnt) mod L2_WAYS:
//   - !busy[w]: sel_way = w, kind EVICT, go to OUT.
//   - else if cnt == L2_WAYS-1: sel_way = ptr, kind STALL, go to OUT.
//   - else cnt++.
//  Latency (accept to sel_valid): 1 cycle for HIT, FILL, and EVICT at ptr. 1+k cycles when k ways are skipped.
//   STALL is reported after L2_WAYS cycles.
//  OUT: sel_valid = 1, outputs held stable until sel_ready; then go to IDLE (one-cycle bubble).
//  Pointer update: only on sel_valid && sel_ready with kind EVICT.
//   - evict_ptr[set] = (sel_way + 1) mod L2_WAYS (wraps from L2_WAYS-1 to 0).
//   - HIT, FILL and STALL leave the pointer unchanged.
//  way_busy changes after accept are ignored (the latched copy is used).
//  sel_req_valid while not ready: the request is not taken; the upstream stage holds it.
// CONFIGURATION
//  L2_WAY_SEL_STATS_EN defined:
//   - stat_hits, stat_fills, stat_evicts, stat_stalls count completed handshakes by kind.
//   - 32-bit counters, saturating at 32'hFFFF_FFFF; cleared by reset.
//  Not defined: all stat_* are tied to 0 and no counter flops are built.
// TESTING
//  1. Reset, set 5: tag_hit=1, way_hit=3 -> next cycle sel_valid=1, sel_way=3, kind 00; evict_way_buf(set 5)=0.
//  2. Set 5: no hit, empty_way_found=1, empty_way=6 -> sel_way=6, kind 01; pointer stays 0.
//  3. Set 5: no hit, no empty, busy=8'h00, ptr=7 -> sel_way=7, kind 10.
//     After handshake, evict_way_buf(set 5)=0 (wrap).
//  4. Set 9: ptr=2, busy=8'b0001_1100 -> sel_way=5, kind 10, sel_valid 4 cycles after accept; ptr becomes 6.
//  5. Set 9: busy=8'hFF -> kind 11 after 8 cycles, sel_way=ptr, pointer unchanged.
//     Hold sel_ready=0 for 3 cycles -> outputs stable throughout.
//  6. Assert rst=0 during SCAN -> sel_valid=0 immediately; pointers 0; with L2_WAY_SEL_STATS_EN all counts 0.

Source files
------------

// File: rtl/l2_way_select_if.sv
// Request/result bundle between the L2 tag lookup stage, l2_way_select and its consumer.
// master = lookup stage + result consumer, slave = l2_way_select.
interface l2_way_select_if #(
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8
);
  localparam int SET_BITS = $clog2(L2_SETS);
  localparam int WAY_BITS = $clog2(L2_WAYS);

  // Request from the tag lookup stage
  logic                sel_req_valid;
  logic                sel_req_ready;
  logic [SET_BITS-1:0] set_in;
  logic                tag_hit;
  logic [WAY_BITS-1:0] way_hit;
  logic                empty_way_found;
  logic [WAY_BITS-1:0] empty_way;
  logic [L2_WAYS-1:0]  way_busy;
  logic [WAY_BITS-1:0] evict_way_buf;

  // Result to the consumer
  logic                sel_valid;
  logic                sel_ready;
  logic [WAY_BITS-1:0] sel_way;
  logic [1:0]          sel_kind;

  // Statistics
  logic [31:0]         stat_hits;
  logic [31:0]         stat_fills;
  logic [31:0]         stat_evicts;
  logic [31:0]         stat_stalls;

  modport master (
    output sel_req_valid, set_in, tag_hit, way_hit, empty_way_found, empty_way, way_busy,
    output sel_ready,
    input  sel_req_ready, evict_way_buf, sel_valid, sel_way, sel_kind,
    input  stat_hits, stat_fills, stat_evicts, stat_stalls
  );

  modport slave (
    input  sel_req_valid, set_in, tag_hit, way_hit, empty_way_found, empty_way, way_busy,
    input  sel_ready,
    output sel_req_ready, evict_way_buf, sel_valid, sel_way, sel_kind,
    output stat_hits, stat_fills, stat_evicts, stat_stalls
  );
endinterface

// File: rtl/l2_way_select.sv
// L2 way selection: hit > empty way > round-robin victim skipping busy ways; owns per-set eviction pointers.
// Optional per-kind handshake counters are built when L2_WAY_SEL_STATS_EN is defined.
module l2_way_select #(
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8
) (
  input logic              clk,
  input logic              rst,
  l2_way_select_if.slave   bus
);
  localparam int SET_BITS = $clog2(L2_SETS);
  localparam int WAY_BITS = $clog2(L2_WAYS);
  localparam logic [WAY_BITS-1:0] LAST_CNT = WAY_BITS'(L2_WAYS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_HIT   = 2'b00,
    KIND_FILL  = 2'b01,
    KIND_EVICT = 2'b10,
    KIND_STALL = 2'b11
  } kind_e;

  state_e              state_q;
  logic [SET_BITS-1:0] set_q;
  logic [L2_WAYS-1:0]  busy_q;
  logic [WAY_BITS-1:0] ptr_q;
  logic [WAY_BITS-1:0] cnt_q;
  logic [WAY_BITS-1:0] sel_way_q;
  kind_e               sel_kind_q;
  logic                sel_valid_q;
  logic [WAY_BITS-1:0] evict_ptr_q [L2_SETS];

  logic                accept;
  logic                handshake;
  logic [WAY_BITS-1:0] cur_ptr;
  logic [WAY_BITS-1:0] scan_way;

  assign accept    = bus.sel_req_valid && (state_q == IDLE);
  assign handshake = sel_valid_q && bus.sel_ready;
  assign cur_ptr   = evict_ptr_q[bus.set_in];
  // Power-of-two associativity: the natural overflow of the add is the mod L2_WAYS wrap.
  assign scan_way  = ptr_q + cnt_q;

  assign bus.sel_req_ready = (state_q == IDLE);
  assign bus.evict_way_buf = cur_ptr;
  assign bus.sel_valid     = sel_valid_q;
  assign bus.sel_way       = sel_way_q;
  assign bus.sel_kind      = sel_kind_q;

  // NOTE: every flop here, including the pointer array, uses non-blocking assignments so all
  // state updates see the pre-edge values; the pointer array is reset because eviction order
  // after reset must start from way 0 in every set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      set_q       <= '0;
      busy_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sel_way_q   <= '0;
      sel_kind_q  <= KIND_HIT;
      sel_valid_q <= 1'b0;
      for (int s = 0; s < L2_SETS; s++) begin
        evict_ptr_q[s] <= '0;
      end
    end else begin
      if (handshake && (sel_kind_q == KIND_EVICT)) begin
        evict_ptr_q[set_q] <= sel_way_q + WAY_BITS'(1);
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            set_q  <= bus.set_in;
            busy_q <= bus.way_busy;
            ptr_q  <= cur_ptr;
            cnt_q  <= WAY_BITS'(1);
            if (bus.tag_hit) begin
              sel_way_q   <= bus.way_hit;
              sel_kind_q  <= KIND_HIT;
              sel_valid_q <= 1'b1;
              state_q     <= OUT;
            end else if (bus.empty_way_found) begin
              sel_way_q   <= bus.empty_way;
              sel_kind_q  <= KIND_FILL;
              sel_valid_q <= 1'b1;
              state_q     <= OUT;
            end else if (!bus.way_busy[cur_ptr]) begin
              sel_way_q   <= cur_ptr;
              sel_kind_q  <= KIND_EVICT;
              sel_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              state_q <= SCAN;
            end
          end
        end

        SCAN: begin
          // Busy flags come from the copy latched at accept, not the live input.
          if (!busy_q[scan_way]) begin
            sel_way_q   <= scan_way;
            sel_kind_q  <= KIND_EVICT;
            sel_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (cnt_q == LAST_CNT) begin
            sel_way_q   <= ptr_q;
            sel_kind_q  <= KIND_STALL;
            sel_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            cnt_q <= cnt_q + WAY_BITS'(1);
          end
        end

        OUT: begin
          if (bus.sel_ready) begin
            sel_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          sel_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef L2_WAY_SEL_STATS_EN
  logic [31:0] stat_hits_q;
  logic [31:0] stat_fills_q;
  logic [31:0] stat_evicts_q;
  logic [31:0] stat_stalls_q;

  // Counters saturate rather than wrap so a long-running total is never misread as small.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits_q   <= '0;
      stat_fills_q  <= '0;
      stat_evicts_q <= '0;
      stat_stalls_q <= '0;
    end else if (handshake) begin
      case (sel_kind_q)
        KIND_HIT:   if (stat_hits_q   != '1) stat_hits_q   <= stat_hits_q   + 32'd1;
        KIND_FILL:  if (stat_fills_q  != '1) stat_fills_q  <= stat_fills_q  + 32'd1;
        KIND_EVICT: if (stat_evicts_q != '1) stat_evicts_q <= stat_evicts_q + 32'd1;
        KIND_STALL: if (stat_stalls_q != '1) stat_stalls_q <= stat_stalls_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.stat_hits   = stat_hits_q;
  assign bus.stat_fills  = stat_fills_q;
  assign bus.stat_evicts = stat_evicts_q;
  assign bus.stat_stalls = stat_stalls_q;
`else
  assign bus.stat_hits   = '0;
  assign bus.stat_fills  = '0;
  assign bus.stat_evicts = '0;
  assign bus.stat_stalls = '0;
`endif

endmodule

// File: tb/tb_l2_way_select.sv
// Self-checking bench for l2_way_select: table-driven requests with a result scoreboard,
// plus hand-written stall/hold and mid-scan reset sequences.
module tb_l2_way_select;
  localparam int L2_SETS = 256;
  localparam int L2_WAYS = 8;

  typedef struct {
    logic [7:0] set;
    logic       tag_hit;
    logic [2:0] way_hit;
    logic       empty_found;
    logic [2:0] empty_way;
    logic [7:0] busy;
    logic [2:0] exp_way;
    logic [1:0] exp_kind;
    int         exp_lat;
    logic [2:0] exp_pb;
    logic [2:0] exp_pa;
  } vec_t;

  typedef struct {
    logic [2:0] way;
    logic [1:0] kind;
    int         lat;
  } res_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  res_t exp_q[$];
  vec_t vecs[12];
  vec_t v_stall;
  vec_t v_post;

  l2_way_select_if #(.L2_SETS(L2_SETS), .L2_WAYS(L2_WAYS)) bus ();

  l2_way_select #(.L2_SETS(L2_SETS), .L2_WAYS(L2_WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge, push its expected result, and leave at the negedge after the accepting edge.
  task automatic issue(input vec_t v, input string name);
    @(negedge clk);
    check({name, "_req_ready"}, 32'(bus.sel_req_ready), 32'd1);
    bus.sel_req_valid   = 1'b1;
    bus.set_in          = v.set;
    bus.tag_hit         = v.tag_hit;
    bus.way_hit         = v.way_hit;
    bus.empty_way_found = v.empty_found;
    bus.empty_way       = v.empty_way;
    bus.way_busy        = v.busy;
    #1;
    check({name, "_ptr_before"}, 32'(bus.evict_way_buf), 32'(v.exp_pb));
    exp_q.push_back('{v.exp_way, v.exp_kind, v.exp_lat});
    @(negedge clk);
    bus.sel_req_valid   = 1'b0;
    bus.tag_hit         = 1'b0;
    bus.empty_way_found = 1'b0;
    // Flip the live busy flags: the block must keep using the copy it latched.
    bus.way_busy        = ~v.busy;
  endtask

  task automatic collect(input string name);
    int   lat;
    res_t e;
    lat = 1;
    while (!bus.sel_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_valid"}, 32'(bus.sel_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_way"}, 32'(bus.sel_way), 32'(e.way));
      check({name, "_kind"}, 32'(bus.sel_kind), 32'(e.kind));
      check({name, "_latency"}, 32'(lat), 32'(e.lat));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //            set    hit   whit   emp   ewy   busy    way   kind   lat pb    pa
    vecs[0]  = '{8'd5,   1'b1, 3'd3, 1'b0, 3'd0, 8'h00, 3'd3, 2'b00, 1, 3'd0, 3'd0};
    vecs[1]  = '{8'd5,   1'b0, 3'd0, 1'b1, 3'd6, 8'h00, 3'd6, 2'b01, 1, 3'd0, 3'd0};
    vecs[2]  = '{8'd5,   1'b0, 3'd0, 1'b0, 3'd0, 8'h3F, 3'd6, 2'b10, 7, 3'd0, 3'd7};
    vecs[3]  = '{8'd5,   1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd7, 2'b10, 1, 3'd7, 3'd0};
    vecs[4]  = '{8'd9,   1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 2'b10, 1, 3'd0, 3'd1};
    vecs[5]  = '{8'd9,   1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd1, 2'b10, 1, 3'd1, 3'd2};
    vecs[6]  = '{8'd9,   1'b0, 3'd0, 1'b0, 3'd0, 8'h1C, 3'd5, 2'b10, 4, 3'd2, 3'd6};
    vecs[7]  = '{8'd9,   1'b1, 3'd2, 1'b1, 3'd4, 8'hFF, 3'd2, 2'b00, 1, 3'd6, 3'd6};
    vecs[8]  = '{8'd9,   1'b0, 3'd0, 1'b1, 3'd4, 8'hFF, 3'd4, 2'b01, 1, 3'd6, 3'd6};
    vecs[9]  = '{8'd9,   1'b0, 3'd0, 1'b0, 3'd0, 8'hC0, 3'd0, 2'b10, 3, 3'd6, 3'd1};
    vecs[10] = '{8'd255, 1'b0, 3'd0, 1'b0, 3'd0, 8'h7F, 3'd7, 2'b10, 8, 3'd0, 3'd0};
    vecs[11] = '{8'd0,   1'b0, 3'd0, 1'b0, 3'd0, 8'h01, 3'd1, 2'b10, 2, 3'd0, 3'd2};
    v_stall  = '{8'd9,   1'b0, 3'd0, 1'b0, 3'd0, 8'hFF, 3'd1, 2'b11, 8, 3'd1, 3'd1};
    v_post   = '{8'd9,   1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 2'b10, 1, 3'd0, 3'd1};

    rst                 = 1'b0;
    bus.sel_req_valid   = 1'b0;
    bus.set_in          = '0;
    bus.tag_hit         = 1'b0;
    bus.way_hit         = '0;
    bus.empty_way_found = 1'b0;
    bus.empty_way       = '0;
    bus.way_busy        = '0;
    bus.sel_ready       = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_sel_valid", 32'(bus.sel_valid), 32'd0);
    check("rst_sel_way", 32'(bus.sel_way), 32'd0);
    check("rst_sel_kind", 32'(bus.sel_kind), 32'd0);
    check("rst_req_ready", 32'(bus.sel_req_ready), 32'd1);
    check("rst_stat_hits", bus.stat_hits, 32'd0);
    check("rst_stat_evicts", bus.stat_evicts, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], $sformatf("v%0d", i));
      collect($sformatf("v%0d", i));
      @(negedge clk);
      check($sformatf("v%0d_valid_dropped", i), 32'(bus.sel_valid), 32'd0);
      check($sformatf("v%0d_ptr_after", i), 32'(bus.evict_way_buf), 32'(vecs[i].exp_pa));
    end

    // All ways busy: STALL after a full scan, held while the consumer back-pressures.
    bus.sel_ready = 1'b0;
    issue(v_stall, "stall");
    collect("stall");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.sel_req_valid = 1'b1;
      bus.set_in        = 8'd9;
      bus.tag_hit       = 1'b1;
      #1;
      check($sformatf("hold%0d_valid", c), 32'(bus.sel_valid), 32'd1);
      check($sformatf("hold%0d_way", c), 32'(bus.sel_way), 32'd1);
      check($sformatf("hold%0d_kind", c), 32'(bus.sel_kind), 32'd3);
      check($sformatf("hold%0d_req_ready", c), 32'(bus.sel_req_ready), 32'd0);
    end
    bus.sel_req_valid = 1'b0;
    bus.tag_hit       = 1'b0;
    bus.sel_ready     = 1'b1;
    @(negedge clk);
    check("stall_valid_dropped", 32'(bus.sel_valid), 32'd0);
    check("stall_ptr_unchanged", 32'(bus.evict_way_buf), 32'd1);
    repeat (3) @(negedge clk);
    check("no_phantom_accept", 32'(bus.sel_valid), 32'd0);

`ifdef L2_WAY_SEL_STATS_EN
    check("stat_hits", bus.stat_hits, 32'd2);
    check("stat_fills", bus.stat_fills, 32'd2);
    check("stat_evicts", bus.stat_evicts, 32'd8);
    check("stat_stalls", bus.stat_stalls, 32'd1);
`else
    check("stat_hits_off", bus.stat_hits, 32'd0);
    check("stat_stalls_off", bus.stat_stalls, 32'd0);
`endif

    // Reset asserted mid-scan drops the request and clears the pointers.
    @(negedge clk);
    bus.sel_req_valid = 1'b1;
    bus.set_in        = 8'd9;
    bus.way_busy      = 8'hFF;
    @(negedge clk);
    bus.sel_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("scan_not_valid", 32'(bus.sel_valid), 32'd0);
    check("scan_ptr_pre_reset", 32'(bus.evict_way_buf), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_sel_valid", 32'(bus.sel_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.sel_req_ready), 32'd1);
    check("midrst_ptr_set9", 32'(bus.evict_way_buf), 32'd0);
    check("midrst_stat_hits", bus.stat_hits, 32'd0);
    check("midrst_stat_fills", bus.stat_fills, 32'd0);
    check("midrst_stat_evicts", bus.stat_evicts, 32'd0);
    check("midrst_stat_stalls", bus.stat_stalls, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_request_dropped", 32'(bus.sel_valid), 32'd0);

    issue(v_post, "post");
    collect("post");
    @(negedge clk);
    check("post_ptr_after", 32'(bus.evict_way_buf), 32'(v_post.exp_pa));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
